// File: rtl/sp_32xn_seq_if.sv
// Host request/response bundle for sp_32xn_seq.
//   master : drives req_valid/req_we/req_addr/req_wdata, observes req_ready/rsp_*
//   slave  : the sequencer side, the mirror image of master
interface sp_32xn_seq_if #(
   parameter int unsigned DW = 4
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [4:0]    req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic [DW-1:0] rsp_data;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/sp_32xn_seq.sv
// Sequencer in front of a 32 x DW single-port synchronous RAM.
// After reset it sweeps FILL into all 32 words, then serves host writes (one per cycle)
// and reads (fixed 2-cycle latency, one per 3 cycles).
// Ports:
//   wclk      : clock, rising edge
//   rst       : synchronous active-high reset
//   host      : request/response bundle (slave modport)
//   init_done : initialisation sweep complete, sticky until rst
//   we/addr/din : registered RAM drive
//   dout      : RAM read data, valid one edge after the RAM samples addr with we=0
module sp_32xn_seq #(
   parameter int unsigned   DW   = 4,
   parameter logic [DW-1:0] FILL = '0
) (
   input  logic          wclk,
   input  logic          rst,
   sp_32xn_seq_if.slave  host,
   output logic          init_done,
   output logic          we,
   output logic [4:0]    addr,
   output logic [DW-1:0] din,
   input  logic [DW-1:0] dout
);

   typedef enum logic [1:0] {StInit, StIdle, StRdWait1, StRdWait2} state_e;

   state_e        state_q, state_d;
   logic [4:0]    cnt_q, cnt_d;
   logic          we_q, we_d;
   logic [4:0]    addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_data_q, rsp_data_d;
   logic          init_done_q, init_done_d;
   logic          req_ready;
   logic          accept;

   // rst gates ready so nothing looks acceptable while reset is asserted
   assign req_ready = (state_q == StIdle) && !rst;
   assign accept    = host.req_valid && req_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      din_d       = din_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      init_done_d = init_done_q;
      unique case (state_q)
         StInit: begin
            // The write to word 31 has just been registered: the sweep is over.
            if (we_q && (addr_q == 5'd31)) begin
               state_d     = StIdle;
               init_done_d = 1'b1;
            end else begin
               we_d   = 1'b1;
               addr_d = cnt_q;
               din_d  = FILL;
               // Saturate so the counter never starts a second sweep
               if (cnt_q != 5'd31) begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         StIdle: begin
            if (accept) begin
               addr_d = host.req_addr;
               if (host.req_we) begin
                  we_d  = 1'b1;
                  din_d = host.req_wdata;
               end else begin
                  state_d = StRdWait1;
               end
            end
         end
         StRdWait1: begin
            // RAM samples addr at this edge
            state_d = StRdWait2;
         end
         StRdWait2: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = dout;
            state_d     = StIdle;
         end
         default: begin
            state_d = StInit;
         end
      endcase
   end

   always_ff @(posedge wclk) begin
      if (rst) begin
         state_q     <= StInit;
         cnt_q       <= 5'd0;
         we_q        <= 1'b0;
         addr_q      <= 5'd0;
         din_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         init_done_q <= init_done_d;
      end
   end

   assign host.req_ready = req_ready;
   assign host.rsp_valid = rsp_valid_q;
   assign host.rsp_data  = rsp_data_q;
   assign init_done      = init_done_q;
   assign we             = we_q;
   assign addr           = addr_q;
   assign din            = din_q;

endmodule

// File: tb/tb_sp_32xn_seq.sv
// Self-checking bench for sp_32xn_seq with a behavioural 32 x DW synchronous RAM.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sp_32xn_seq;
   localparam int unsigned   DW   = 4;
   localparam logic [DW-1:0] FILL = 4'h0;

   logic          wclk;
   logic          rst;
   logic          init_done;
   logic          we;
   logic [4:0]    addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;

   sp_32xn_seq_if #(.DW(DW)) bus ();

   sp_32xn_seq #(.DW(DW), .FILL(FILL)) dut (
      .wclk      (wclk),
      .rst       (rst),
      .host      (bus.slave),
      .init_done (init_done),
      .we        (we),
      .addr      (addr),
      .din       (din),
      .dout      (dout)
   );

   // RAM: write when we, else registered read
   logic [DW-1:0] ram [32];
   always @(posedge wclk) begin
      if (we) ram[addr] <= din;
      else    dout      <= ram[addr];
   end

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int cyc = 0;
   always @(posedge wclk) cyc <= cyc + 1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [DW-1:0] model_mem [32];
   logic [DW-1:0] exp_q [$];
   int            exp_cyc_q [$];
   logic [DW-1:0] mon_e;
   int            mon_c;

   // Scoreboard: every response must match the oldest pending read, 2 edges after acceptance
   always @(negedge wclk) begin
      if (bus.rsp_valid === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rsp_unexpected: rsp_valid=1 data=%h at cycle %0d, no read pending",
                     bus.rsp_data, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            if (bus.rsp_data !== mon_e || cyc != mon_c + 2) begin
               n_fail++;
               $display("FAIL rsp_data: got %h at cycle %0d, need %h at cycle %0d",
                        bus.rsp_data, cyc, mon_e, mon_c + 2);
            end
         end
      end
   end

   // Presents one request and waits (bounded) for acceptance; returns on the falling edge
   // after the accepting edge.
   task automatic issue(input logic w, input logic [4:0] a, input logic [DW-1:0] d,
                        output bit ok);
      bus.req_valid = 1'b1;
      bus.req_we    = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      ok = 1'b0;
      for (int t = 0; t < 64 && !ok; t++) begin
         if (bus.req_ready === 1'b1 && rst === 1'b0) begin
            ok = 1'b1;
            if (w) begin
               model_mem[a] = d;
            end else begin
               exp_q.push_back(model_mem[a]);
               exp_cyc_q.push_back(cyc + 1);
            end
         end
         @(negedge wclk);
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 16 && exp_q.size() != 0; t++) @(negedge wclk);
   endtask

   task automatic model_init();
      for (int i = 0; i < 32; i++) model_mem[i] = FILL;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge wclk);
      n_cmp++;
      if (we !== 1'b0 || addr !== 5'd0 || din !== '0 || bus.rsp_valid !== 1'b0 ||
          bus.rsp_data !== '0 || init_done !== 1'b0 || bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: we=%b addr=%0d din=%h rv=%b rd=%h done=%b rdy=%b, need all 0",
                  we, addr, din, bus.rsp_valid, bus.rsp_data, init_done, bus.req_ready);
      end
      rst = 1'b0;
      model_init();
      for (int i = 0; i < 32; i++) begin
         @(negedge wclk);
         n_cmp++;
         if (we !== 1'b1 || addr !== 5'(i) || din !== FILL || init_done !== 1'b0 ||
             bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL init_sweep[%0d]: we=%b addr=%0d din=%h done=%b rdy=%b, need 1 %0d %h 0 0",
                     i, we, addr, din, init_done, bus.req_ready, i, FILL);
         end
      end
      @(negedge wclk);
      n_cmp++;
      if (init_done !== 1'b1 || we !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL init_exit: done=%b we=%b rdy=%b, need 1 0 1", init_done, we, bus.req_ready);
      end
      // Sweep must not wrap into a second pass
      repeat (3) @(negedge wclk);
      n_cmp++;
      if (we !== 1'b0 || init_done !== 1'b1) begin
         n_fail++;
         $display("FAIL init_no_wrap: we=%b done=%b, need 0 1", we, init_done);
      end
   endtask

   task automatic test_write_read();
      bit ok;
      issue(1'b1, 5'd5, 4'hA, ok);
      n_cmp++;
      if (!ok || we !== 1'b1 || addr !== 5'd5 || din !== 4'hA) begin
         n_fail++;
         $display("FAIL wr5: ok=%b we=%b addr=%0d din=%h, need 1 1 5 a", ok, we, addr, din);
      end
      issue(1'b0, 5'd5, 4'h0, ok);
      n_cmp++;
      if (!ok || we !== 1'b0 || addr !== 5'd5 || bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rd5_wait1: ok=%b we=%b addr=%0d rdy=%b, need 1 0 5 0",
                  ok, we, addr, bus.req_ready);
      end
      @(negedge wclk);
      n_cmp++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rd5_wait2: rdy=%b rv=%b, need 0 0", bus.req_ready, bus.rsp_valid);
      end
      @(negedge wclk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 4'hA || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rd5_rsp: rv=%b rd=%h rdy=%b, need 1 a 1",
                  bus.rsp_valid, bus.rsp_data, bus.req_ready);
      end
      repeat (3) @(negedge wclk);
      n_cmp++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 4'hA || we !== 1'b0 || addr !== 5'd5) begin
         n_fail++;
         $display("FAIL rsp_hold: rv=%b rd=%h we=%b addr=%0d, need 0 a 0 5",
                  bus.rsp_valid, bus.rsp_data, we, addr);
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      int c0;
      for (int i = 0; i < 4; i++) begin
         c0 = cyc;
         issue(1'b1, 5'(i), 4'(i + 1), ok);
         n_cmp++;
         if (!ok || cyc != c0 + 1 || we !== 1'b1 || addr !== 5'(i) || din !== 4'(i + 1) ||
             bus.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_wr[%0d]: ok=%b cycles=%0d we=%b addr=%0d din=%h rdy=%b, need 1 1 1 %0d %0d 1",
                     i, ok, cyc - c0, we, addr, din, bus.req_ready, i, i + 1);
         end
      end
      // First read directly follows the last write
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 5'(i), 4'h0, ok);
         n_cmp++;
         if (!ok) begin
            n_fail++;
            $display("FAIL b2b_rd_accept[%0d]: accepted=0, need 1", i);
         end
      end
      drain();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_drain: pending=%0d, need 0", exp_q.size());
      end
   endtask

   task automatic test_unwritten();
      bit ok;
      issue(1'b0, 5'd20, 4'h0, ok);
      drain();
      n_cmp++;
      if (!ok || exp_q.size() != 0 || bus.rsp_data !== FILL) begin
         n_fail++;
         $display("FAIL rd20_fill: ok=%b pending=%0d rd=%h, need 1 0 %h",
                  ok, exp_q.size(), bus.rsp_data, FILL);
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      issue(1'b0, 5'd3, 4'h0, ok);
      rst = 1'b1;
      @(negedge wclk);
      rst = 1'b0;
      exp_q.delete();
      exp_cyc_q.delete();
      model_init();
      n_cmp++;
      if (!ok || we !== 1'b0 || addr !== 5'd0 || init_done !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_read: ok=%b we=%b addr=%0d done=%b rv=%b, need 1 0 0 0 0",
                  ok, we, addr, init_done, bus.rsp_valid);
      end
      for (int i = 0; i < 32; i++) begin
         @(negedge wclk);
         n_cmp++;
         if (we !== 1'b1 || addr !== 5'(i) || init_done !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL resweep[%0d]: we=%b addr=%0d done=%b rv=%b, need 1 %0d 0 0",
                     i, we, addr, init_done, bus.rsp_valid, i);
         end
      end
      @(negedge wclk);
      // Word 0 held 1 before the reset; the re-sweep must have cleared it
      issue(1'b0, 5'd0, 4'h0, ok);
      drain();
      n_cmp++;
      if (!ok || exp_q.size() != 0 || bus.rsp_data !== FILL) begin
         n_fail++;
         $display("FAIL resweep_rd0: ok=%b pending=%0d rd=%h, need 1 0 %h",
                  ok, exp_q.size(), bus.rsp_data, FILL);
      end
   endtask

   task automatic test_held_from_reset();
      bit ok;
      issue(1'b1, 5'd7, 4'h9, ok);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = 5'd7;
      bus.req_wdata = 4'h0;
      rst = 1'b1;
      repeat (2) @(negedge wclk);
      rst = 1'b0;
      model_init();
      for (int i = 0; i < 32; i++) begin
         @(negedge wclk);
         n_cmp++;
         if (we !== 1'b1 || addr !== 5'(i) || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL held_sweep[%0d]: we=%b addr=%0d rdy=%b, need 1 %0d 0",
                     i, we, addr, bus.req_ready, i);
         end
      end
      @(negedge wclk);
      n_cmp++;
      if (init_done !== 1'b1 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL held_idle: done=%b rdy=%b, need 1 1", init_done, bus.req_ready);
      end
      exp_q.push_back(model_mem[7]);
      exp_cyc_q.push_back(cyc + 1);
      @(negedge wclk);
      bus.req_valid = 1'b0;
      n_cmp++;
      if (we !== 1'b0 || addr !== 5'd7 || bus.req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL held_accept: we=%b addr=%0d rdy=%b, need 0 7 0", we, addr, bus.req_ready);
      end
      drain();
      n_cmp++;
      if (exp_q.size() != 0 || bus.rsp_data !== FILL) begin
         n_fail++;
         $display("FAIL held_rsp: pending=%0d rd=%h, need 0 %h", exp_q.size(), bus.rsp_data, FILL);
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = 5'd0;
      bus.req_wdata = '0;
      dout          = '0;
      for (int i = 0; i < 32; i++) ram[i] = 4'($urandom_range(1, 15));
      model_init();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_unwritten();
      test_reset_mid_read();
      test_held_from_reset();
      repeat (4) @(negedge wclk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, need finished", $time);
      $fatal(1);
   end
endmodule

// File: doc/sp_32xn_seq.md
SP_32XN_SEQ -- requirements
Module: sp_32xn_seq

Interface
REQ-001 The module SHALL have parameter DW, default 4, giving the data width of the memory word and the request/response data.
REQ-002 The module SHALL have parameter FILL, default 0 (DW bits), giving the value written to every word during initialisation.
REQ-003 The module SHALL have port wclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port req_valid, input, 1 bit: a host request is present.
REQ-006 The module SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The module SHALL have port req_we, input, 1 bit: 1 = write request, 0 = read request.
REQ-008 The module SHALL have port req_addr, input, 5 bits: word address 0..31.
REQ-009 The module SHALL have port req_wdata, input, DW bits: write data.
REQ-010 The module SHALL have port rsp_valid, output, 1 bit: one-cycle pulse marking rsp_data valid.
REQ-011 The module SHALL have port rsp_data, output, DW bits: read data.
REQ-012 The module SHALL have port init_done, output, 1 bit: the initialisation sweep is complete.
REQ-013 The module SHALL have ports we (output, 1 bit), addr (output, 5 bits) and din (output, DW bits): registered drive to the 32xDW single-port RAM.
REQ-014 The module SHALL have port dout, input, DW bits: RAM read data, valid one wclk edge after the RAM samples addr with we=0.

Function
REQ-015 The FSM SHALL have states INIT, IDLE, RD_WAIT1 and RD_WAIT2.
REQ-016 Acceptance SHALL occur at a rising edge where req_valid=1 and req_ready=1.
REQ-017 req_ready SHALL be combinational: 1 only in IDLE.
REQ-018 INIT: at edge N after rst deasserts (N=1..32), the block SHALL register we=1, addr=N-1, din=FILL.
REQ-019 INIT exit: at edge 33, the block SHALL register we=0 and init_done=1, and move to IDLE.
REQ-020 INIT counter: a 5-bit counter SHALL drive the sweep; after the addr=31 write it SHALL NOT wrap into a second sweep.
REQ-021 Write accepted in IDLE: at the accepting edge, the block SHALL register we=1, addr=req_addr, din=req_wdata, and remain in IDLE.
REQ-022 Write throughput SHALL be back-to-back, one write per cycle.
REQ-023 IDLE with no write accepted: at that edge, we SHALL go to 0 while addr and din hold their values.
REQ-024 Read accepted at edge E0: at E0, the block SHALL register we=0, addr=req_addr, and move to RD_WAIT1.
REQ-025 Read, edge E1: the block SHALL move to RD_WAIT2.
REQ-026 Read, edge E2: the block SHALL register rsp_data=dout and rsp_valid=1, and move to IDLE.
REQ-027 rsp_valid SHALL be 1 for exactly one cycle per read.
REQ-028 rsp_data SHALL hold its value until the next read capture.
REQ-029 There SHALL be no response backpressure.
REQ-030 Read latency SHALL be fixed at 2 cycles from acceptance to rsp_valid.
REQ-031 Read throughput SHALL be at most one read per 3 cycles.
REQ-032 Requests presented while in INIT, RD_WAIT1 or RD_WAIT2 SHALL NOT be accepted, and the host SHALL hold req_*.
REQ-033 A request held from reset release SHALL be accepted at the first edge in IDLE.
REQ-034 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-035 init_done SHALL stay 1 until the next rst.

Reset
REQ-036 While rst=1 at an edge, the block SHALL set state=INIT, INIT counter=0, we=0, addr=0, din=0, rsp_valid=0, rsp_data=0, init_done=0.
REQ-037 While rst=1, req_ready SHALL be 0.
REQ-038 Reset mid-read (RD_WAIT1/RD_WAIT2) SHALL cancel the read, with no rsp_valid pulse.
REQ-039 Reset mid-INIT SHALL restart the sweep at addr=0.
REQ-040 Reset SHALL have priority over every other event at the same edge.

Verification
REQ-041 Reset release, FILL=0 -> the bench SHALL check 32 consecutive cycles of we=1, addr 0..31, din=0; at edge 33, init_done=1, we=0, req_ready=1.
REQ-042 Write addr 5 data 0xA, then read addr 5 -> the bench SHALL check rsp_valid=1 with rsp_data=0xA exactly 2 cycles after read acceptance, and req_ready=0 during both wait cycles.
REQ-043 Writes to addr 0..3, data 1..4, on consecutive cycles -> the bench SHALL check req_ready stays 1 and we=1 for 4 cycles; subsequent reads SHALL return 1, 2, 3, 4 in order.
REQ-044 Read of unwritten addr 20 after init -> the bench SHALL check rsp_data=FILL (0).
REQ-045 req_valid=1 (read addr 7) held from reset release -> the bench SHALL check no acceptance before init_done, acceptance at the first IDLE edge, and rsp_valid 2 cycles later.
REQ-046 rst pulsed for 1 cycle while in RD_WAIT1 -> the bench SHALL check no rsp_valid pulse and the INIT sweep restarting at addr=0 with init_done=0.
